// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial WIDTH-bit subtractor (diff = a - b mod 2^WIDTH)
// built around one shared full_subtractor cell, processed LSB-first, one bit per clock.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, accepted only while ready=1
//   a, b   minuend / subtrahend, sampled on the accepting edge only
//   ready  1 while idle (can accept start)
//   done   one-cycle pulse when diff/bout hold a new result
//   diff   a - b modulo 2^WIDTH, held until the next done
//   bout   final borrow out (1 when a < b unsigned)
//   ovf    signed overflow, present only when SUB_OVF_EN is defined
//
// Optional feature macro: SUB_OVF_EN (adds the ovf output and its capture logic).
//
// Latency: start accepted at edge E0 -> done high after edge E0+WIDTH, next start
// accepted at E0+WIDTH+2. All outputs are registered.

module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter wide enough to hold WIDTH, never narrower than one bit.
    localparam int unsigned CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result bits enter at the MSB and move right, so after WIDTH shifts the
    // first (LSB) difference bit sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_diff;
        end else begin : g_res_wn
            assign res_next = {cell_diff, res_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= 1'b0;
                        cnt   <= '0;
                        ready <= 1'b0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    brw    <= cell_bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff  <= res_next;
                        bout  <= cell_bout;
`ifdef SUB_OVF_EN
                        // brw is the borrow into the MSB on this last step.
                        ovf   <= brw ^ cell_bout;
`endif
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// full_subtractor: one-bit subtract cell, diff = a - b - bin, bout = borrow out.
//   a, b, bin  operand bits and borrow in
//   diff, bout difference bit and borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed vector table, hand-written
// multi-cycle sequences (held start, mid-run reset, WIDTH=1) and random operands
// checked against an arithmetic reference model.

module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       bout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       ready1;
    logic       done1;
    logic [0:0] diff1;
    logic       bout1;

`ifdef SUB_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] last_diff;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ready (ready1),
        .done  (done1),
        .diff  (diff1),
        .bout  (bout1)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y);
        int d;
        int sd;
        logic [7:0] dm;
        d  = int'(x) - int'(y);
        sd = int'($signed(x)) - int'($signed(y));
        dm = 8'(d & 255);
        return {(sd > 127 || sd < -128), (d < 0), dm};
    endfunction

    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] ed,
                          input logic eb, input logic eo, input string nm);
        int   cyc;
        logic hold_ok;
        @(negedge clk);
        check({nm, " ready"}, 32'(ready), 32'd1);
        start = 1'b1;
        a     = ai;
        b     = bi;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cyc     = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (diff !== last_diff) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({nm, " hold"}, 32'(hold_ok), 32'd1);
        check({nm, " latency"}, 32'(cyc), 32'd8);
        check({nm, " diff"}, 32'(diff), 32'(ed));
        check({nm, " bout"}, 32'(bout), 32'(eb));
`ifdef SUB_OVF_EN
        check({nm, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) check({nm, " ovf"}, 32'(eo), 32'd0);
`endif
        check({nm, " ready_in_done"}, 32'(ready), 32'd0);
        last_diff = ed;
        @(negedge clk);
        check({nm, " done_pulse"}, 32'(done), 32'd0);
        check({nm, " ready_after"}, 32'(ready), 32'd1);
    endtask

    task automatic run_op1(input logic ai, input logic bi, input logic ed, input logic eb,
                           input logic eo, input string nm);
        int cyc;
        @(negedge clk);
        check({nm, " ready"}, 32'(ready1), 32'd1);
        start1 = 1'b1;
        a1     = ai;
        b1     = bi;
        @(negedge clk);
        start1 = 1'b0;
        a1     = ~ai;
        b1     = ~bi;
        cyc    = 0;
        while (done1 !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, " latency"}, 32'(cyc), 32'd1);
        check({nm, " diff"}, 32'(diff1), 32'(ed));
        check({nm, " bout"}, 32'(bout1), 32'(eb));
`ifdef SUB_OVF_EN
        check({nm, " ovf"}, 32'(ovf1), 32'(eo));
`else
        if (eo === 1'bx) check({nm, " ovf"}, 32'(eo), 32'd0);
`endif
        @(negedge clk);
        check({nm, " ready_after"}, 32'(ready1), 32'd1);
    endtask

    initial begin
        int         n;
        int         cyc;
        logic       hold_ok;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [9:0] m;

        vecs[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bo: 1'b1, ov: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[3] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        vecs[5] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        vecs[6] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, ov: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1, ov: 1'b0};
        vecs[8] = '{a: 8'h80, b: 8'h7F, d: 8'h01, bo: 1'b0, ov: 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset ready1", 32'(ready1), 32'd1);
        last_diff = 8'h00;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov,
                   $sformatf("vec%0d", i));
        end

        // start held high with new operands during RUN: exactly one result, from 10-01.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        a       = 8'hAA;
        b       = 8'h55;
        cyc     = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (diff !== last_diff) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("held hold", 32'(hold_ok), 32'd1);
        check("held latency", 32'(cyc), 32'd8);
        check("held diff", 32'(diff), 32'h0F);
        check("held bout", 32'(bout), 32'd0);
        n = (done === 1'b1) ? 1 : 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("held done_count", 32'(n), 32'd1);
        last_diff = 8'h0F;

        // Reset in the middle of RUN aborts the op silently.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort ready", 32'(ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("abort no_done", 32'(n), 32'd0);
        last_diff = 8'h00;

        // WIDTH=1 instance.
        run_op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "w1 0-1");
        run_op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "w1 1-1");
        run_op1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1 1-0");
        run_op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1 0-0");

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            m  = model(ra, rb);
            run_op(ra, rb, m[7:0], m[8], m[9], $sformatf("rnd%0d %0h-%0h", i, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
